// File: rtl/agm_fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake and
// buffers words in a show-ahead prefetch queue presented to decode via valid/ready.
module agm_fetch_queue #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CMD_W    = 24,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic [CMD_W-1:0]            mem_rdata,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [CMD_W-1:0]            cmd_word,
    output logic [ADDR_W-1:0]           cmd_pc,
    input  logic                        br_en,
    input  logic [ADDR_W-1:0]           br_target,
    input  logic                        halt,
    output logic [ADDR_W-1:0]           PC_wire,
    output logic [1:0]                  state_out,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     count, count_nxt;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              push, pop;

    logic [CMD_W-1:0]  q_word [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];

    always_comb begin
        push      = (state == REQ) && mem_ack && !br_en;
        pop       = (count != '0) && cmd_ready && !br_en;
        count_nxt = count + CW'(push) - CW'(pop);
        state_nxt = state;
        // Full/refill decisions use post-edge occupancy so a pop re-opens fetch at once.
        if (br_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = halt ? HALT : REQ;
                REQ: begin
                    if (mem_ack) begin
                        if (halt)
                            state_nxt = HALT;
                        else if (count_nxt == CW'(QDEPTH))
                            state_nxt = FULL;
                        else
                            state_nxt = REQ;
                    end
                end
                FULL: begin
                    if (halt)
                        state_nxt = HALT;
                    else if (count_nxt < CW'(QDEPTH))
                        state_nxt = REQ;
                end
                HALT: begin
                    if (!halt)
                        state_nxt = (count_nxt < CW'(QDEPTH)) ? REQ : FULL;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= ADDR_W'(RESET_PC);
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (br_en) begin
                pc     <= br_target;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) begin
                    pc     <= pc + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_word[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= pc;
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_addr  = pc;
    assign cmd_valid = (count != '0);
    assign cmd_word  = cmd_valid ? q_word[rd_ptr] : '0;
    assign cmd_pc    = cmd_valid ? q_pc[rd_ptr] : '0;
    assign PC_wire   = pc;
    assign state_out = state;
    assign q_count   = count;

endmodule
